// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial packed-BCD adder.
//   BCD_W / BCD_MAX : width and largest legal value of one BCD digit
//   state_t         : sequencing states of the top-level FSM
//   idx_width()     : bit width of the digit index for a given digit count
package bcd_serial_adder_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-digit adder still needs a 1-bit index register.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder, purely combinational.
//   a, b : BCD digits (values above 9 are still processed)
//   ci   : decimal carry-in
//   s    : corrected BCD digit
//   co   : decimal carry-out
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             ci,
  output logic [BCD_W-1:0] s,
  output logic             co
);

  logic [BCD_W:0] t;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    t  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, ci};
    s  = t[BCD_W-1:0];
    co = 1'b0;
    if (t > (BCD_W+1)'(BCD_MAX)) begin
      // Adding 6 skips the six unused codes; the mod-16 wrap is the truncation.
      s  = BCD_W'(t + (BCD_W+1)'(6));
      co = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, LSD first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only in IDLE
//   a, b, cin  : packed-BCD operands and decimal carry-in (captured on start)
//   busy       : high while digits are being added
//   done       : one-cycle pulse when sum/cout/invalid are valid
//   sum, cout  : packed-BCD result and top-digit carry, held until next start
//   invalid    : an operand digit exceeded 9 at capture, held with sum
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] sum,
  output logic                    cout,
  output logic                    invalid
);

  localparam int W  = BCD_W * DIGITS;
  localparam int IW = idx_width(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [BCD_W-1:0] dig_s;
  logic             dig_co;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    has_bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[BCD_W*i +: BCD_W] > BCD_W'(BCD_MAX)) has_bad_digit = 1'b1;
  endfunction

  // Operand registers shift right, so the current digit is always at [3:0].
  bcd_digit_add u_digit (
    .a  (a_q[BCD_W-1:0]),
    .b  (b_q[BCD_W-1:0]),
    .ci (carry),
    .s  (dig_s),
    .co (dig_co)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry   <= cin;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= has_bad_digit(a) | has_bad_digit(b);
            busy    <= 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          sum[BCD_W*int'(idx) +: BCD_W] <= dig_s;
          carry <= dig_co;
          a_q   <= a_q >> BCD_W;
          b_q   <= b_q >> BCD_W;
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            cout  <= dig_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): directed cases from
// the test plan plus randomized operands, compared against a decimal model.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         invalid;

  int vectors = 0;
  int errors  = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Valid operands: plain decimal arithmetic modulo 10^DIGITS.
  // Invalid operands: digit-by-digit with the >9 correction rule.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                       output logic [W-1:0] s, output logic co, output logic inv);
    int modulus = 1;
    int total;
    int c;
    int t;
    for (int i = 0; i < DIGITS; i++) modulus *= 10;
    inv = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) inv = 1'b1;
    if (!inv) begin
      total = bcd_to_int(av) + bcd_to_int(bv) + int'(ci);
      co = (total >= modulus);
      s  = int_to_bcd(total % modulus);
    end else begin
      c = int'(ci);
      s = '0;
      for (int i = 0; i < DIGITS; i++) begin
        t = int'(av[4*i +: 4]) + int'(bv[4*i +: 4]) + c;
        if (t > 9) begin
          s[4*i +: 4] = 4'((t + 6) % 16);
          c = 1;
        end else begin
          s[4*i +: 4] = 4'(t);
          c = 0;
        end
      end
      co = (c != 0);
    end
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(9));
    return r;
  endfunction

  // One complete transaction. With disturb set, start is held high and the
  // operands are scrambled throughout ADD, and start is raised again while
  // done is high; neither may affect the result or launch a second add.
  task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input bit disturb);
    logic [W-1:0] exp_s;
    logic         exp_co;
    logic         exp_inv;
    int           busy_cyc = 0;
    int           waited = 0;
    model(av, bv, ci, exp_s, exp_co, exp_inv);
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(negedge clk);
    if (!disturb) start = 1'b0;
    while (!done && waited < 20) begin
      if (busy) busy_cyc++;
      if (disturb) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      waited++;
    end
    start = disturb ? 1'b1 : 1'b0;   // start while done is high must be ignored
    check("done_seen", {31'd0, done}, 32'd1);
    check("busy_cycles", busy_cyc, DIGITS);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("sum", {16'd0, sum}, {16'd0, exp_s});
    check("cout", {31'd0, cout}, {31'd0, exp_co});
    check("invalid", {31'd0, invalid}, {31'd0, exp_inv});
    @(negedge clk);
    start = 1'b0;
    check("done_width", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("no_restart", {30'd0, busy, done}, 32'd0);
    check("sum_hold", {16'd0, sum}, {16'd0, exp_s});
    check("cout_hold", {31'd0, cout}, {31'd0, exp_co});
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_invalid", {31'd0, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_add(16'h0000, 16'h0000, 1'b0, 1'b0);
    do_add(16'h9999, 16'h0001, 1'b0, 1'b0);
    do_add(16'h1234, 16'h5678, 1'b0, 1'b0);
    do_add(16'h0999, 16'h0001, 1'b1, 1'b0);
    do_add(16'h000A, 16'h0000, 1'b0, 1'b0);
    do_add(16'h4321, 16'h1111, 1'b0, 1'b0);   // invalid must clear
    do_add(16'h9999, 16'h9999, 1'b1, 1'b0);
    do_add(16'h2468, 16'h1357, 1'b1, 1'b1);   // handshake disturbance

    // Reset mid-operation
    @(negedge clk);
    a = 16'h5555; b = 16'h4444; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_sum", {16'd0, sum}, 32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DIGITS + 2; i++) begin
      @(negedge clk);
      check("midrst_no_done", {30'd0, busy, done}, 32'd0);
    end
    do_add(16'h5555, 16'h4444, 1'b1, 1'b0);

    // Randomized valid operands
    for (int i = 0; i < 40; i++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      do_add(ra, rb, 1'($urandom), (i % 8) == 7);
    end
    // Randomized raw nibbles (mostly invalid)
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_add(ra, rb, 1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
